qpsk_demapper_deframer: RTL and testbench
=========================================

Name: qpsk_demapper_deframer

Overview:
Receive-side consumer placed directly downstream of the QPSK modulator output (I_comp/Q_comp, clk_50 domain).
- Hard-decision demaps each symbol to a dibit.
- Tracks 96-symbol frame boundaries and aborts on mid-frame gaps.
- Buffers dibits in a first-word-fall-through FIFO with valid/ready output.
- Feeds a loopback checker or board debug port.

Parameters:
SYMS_PER_FRAME, 96, symbols per frame (one 192-bit interleaved block).
FIFO_DEPTH, 16, dibit FIFO entries (power of 2).
GAP_MAX, 4, max consecutive idle cycles tolerated inside a frame.
NOM_AMP, 16'sh5A82, nominal |I|/|Q| magnitude (0.7071, Q15).
AMP_TOL, 16'd512, allowed magnitude deviation.

Ports:
clk_50  in  1  50 MHz clock; all logic on posedge.
reset_N  in  1  reset, asynchronous, active-low.
valid_in  in  1  modulator symbol valid.
I_comp  in  16  signed Q15 in-phase sample.
Q_comp  in  16  signed Q15 quadrature sample.
ready_out  out  1  block can accept a symbol (to modulator ready_in).
dibit_out  out  2  {I_bit, Q_bit} at FIFO head.
dibit_sof  out  1  head dibit is symbol 0 of a frame.
dibit_eof  out  1  head dibit is the last symbol of a frame.
dibit_valid  out  1  FIFO not empty.
dibit_ready  in  1  downstream pops head when high with dibit_valid.
sym_index  out  7  index of next expected symbol in frame.
frame_done  out  1  one-cycle pulse on acceptance of final frame symbol.
frame_count  out  16  completed frames, wraps at 65535->0.
frame_abort  out  1  sticky: a frame was aborted by a gap.
overflow  out  1  sticky: symbol arrived while ready_out low.
fifo_level  out  5  current FIFO occupancy, 0..FIFO_DEPTH.
amp_err_count  out  8  saturating magnitude-error count (optional feature).

Behaviour:
- Reset values: all outputs 0, except ready_out = 1 once reset deasserts. FIFO empty, FSM in IDLE, gap counter 0.
- Demap: I_bit = I_comp[15], Q_bit = Q_comp[15]. Negative maps to 1; zero maps to 0.
- Accept: valid_in && ready_out. ready_out = (fifo_level != FIFO_DEPTH), combinational from registered level.
- Drop: valid_in && !ready_out sets overflow (sticky until reset). The symbol is not written, but still advances sym_index so frame alignment holds.
- FSM:
  - IDLE: sym_index = 0. On any symbol (accepted or dropped) -> FRAME, sym_index = 1, sof tag set on that entry.
  - FRAME: each symbol increments sym_index. The symbol with sym_index == SYMS_PER_FRAME-1 gets the eof tag, pulses frame_done, increments frame_count, and -> IDLE (sym_index = 0).
  - FRAME gap: valid_in low increments the gap counter; any symbol clears it. Gap counter reaching GAP_MAX -> frame_abort set, sym_index = 0, -> IDLE. Entries already queued stay in the FIFO.
- FIFO: entry = {sof, eof, dibit}. Write latency 1: a symbol accepted at edge N is visible at the head after edge N if the FIFO was empty. Pop on dibit_valid && dibit_ready.
- Simultaneous push and pop: level unchanged. Pop on empty is ignored. Pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame: FIFO contents discarded, all counters and stickies cleared.

Optional Feature:
Macro QPSK_DEMAP_AMP_CHECK_EN.
- Defined: for each accepted symbol, compute |I| and |Q|, with |-32768| saturating to 32767. If either differs from NOM_AMP by more than AMP_TOL, amp_err_count increments, saturating at 255. Registered, 1-cycle latency.
- Undefined: amp_err_count tied to 0; no magnitude logic synthesized.

Test Plan:
1. Reset, then 96 back-to-back symbols alternating (+0x5A82,+0x5A82)/(-0x5A82,-0x5A82), dibit_ready=1 -> dibits alternate 00/11; sof on first, eof on 96th; frame_done pulses once; frame_count=1; overflow=0.
2. dibit_ready=0, push 20 symbols -> fifo_level reaches 16, ready_out drops; symbols 17-20 set overflow; sym_index=20.
3. 40 symbols, then valid_in low 4 cycles -> frame_abort=1, sym_index=0; next symbol carries sof.
4. Push and pop every cycle at fifo_level=8 for 10 cycles -> fifo_level stays 8; output order matches input order.
5. Assert reset_N low mid-frame at symbol 50 with 6 entries queued -> all outputs 0 asynchronously; after release, a full 96-symbol frame completes normally.
6. With QPSK_DEMAP_AMP_CHECK_EN: symbols I=0x5A82 (pass), I=0x4000 (fail), I=0x8000 (fail) -> amp_err_count=2.

Source files
------------

// File: rtl/qpsk_demapper_deframer_if.sv
// Symbol-in / dibit-out handshake bundle for the QPSK demapper-deframer.
// master = upstream modulator plus downstream consumer; slave = the demapper itself.
interface qpsk_demapper_deframer_if;
  logic               valid_in;
  logic signed [15:0] I_comp;
  logic signed [15:0] Q_comp;
  logic               ready_out;
  logic [1:0]         dibit_out;
  logic               dibit_sof;
  logic               dibit_eof;
  logic               dibit_valid;
  logic               dibit_ready;

  modport master (
    output valid_in, I_comp, Q_comp, dibit_ready,
    input  ready_out, dibit_out, dibit_sof, dibit_eof, dibit_valid
  );

  modport slave (
    input  valid_in, I_comp, Q_comp, dibit_ready,
    output ready_out, dibit_out, dibit_sof, dibit_eof, dibit_valid
  );
endinterface

// File: rtl/qpsk_demapper_deframer.sv
// Hard-decision QPSK demapper with 96-symbol frame tracking and a FWFT dibit FIFO.
// Optional magnitude checker enabled by defining QPSK_DEMAP_AMP_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for symbol 0 of a frame, sym_index = 0
// FRAME | inside a frame, counting symbols and idle gaps
module qpsk_demapper_deframer #(
  parameter int SYMS_PER_FRAME = 96,
  parameter int FIFO_DEPTH     = 16,
  parameter int GAP_MAX        = 4
`ifdef QPSK_DEMAP_AMP_CHECK_EN
  ,
  parameter logic signed [15:0] NOM_AMP = 16'sh5A82,
  parameter logic [15:0]        AMP_TOL = 16'd512
`endif
) (
  input  logic                          clk_50,
  input  logic                          reset_N,
  qpsk_demapper_deframer_if.slave       bus,
  output logic [6:0]                    sym_index,
  output logic                          frame_done,
  output logic [15:0]                   frame_count,
  output logic                          frame_abort,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    amp_err_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = $clog2(GAP_MAX + 1);
  localparam logic [6:0]  LAST_IDX = 7'(SYMS_PER_FRAME - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_MAX - 1);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {IDLE, FRAME} state_t;

  state_t          state_q, state_d;
  logic [6:0]      sym_idx_q, sym_idx_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            done_q, done_d;
  logic [15:0]     count_q, count_d;
  logic            abort_q, abort_d;
  logic            ovf_q, ovf_d;
  logic [AW:0]     level_q, level_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]      mem_q [FIFO_DEPTH];
  logic [3:0]      mem_d [FIFO_DEPTH];
  logic            sof_tag, eof_tag, push, pop;

  // Gating with reset_N keeps ready_out low while reset is held.
  assign bus.ready_out   = reset_N && (level_q != FULL_LVL);
  assign bus.dibit_valid = (level_q != '0);
  assign push = bus.valid_in && bus.ready_out;
  assign pop  = bus.dibit_valid && bus.dibit_ready;

  assign bus.dibit_sof = bus.dibit_valid & mem_q[rd_ptr_q][3];
  assign bus.dibit_eof = bus.dibit_valid & mem_q[rd_ptr_q][2];
  assign bus.dibit_out = bus.dibit_valid ? mem_q[rd_ptr_q][1:0] : 2'b00;

  always_comb begin
    state_d   = state_q;
    sym_idx_d = sym_idx_q;
    gap_d     = gap_q;
    done_d    = 1'b0;
    count_d   = count_q;
    abort_d   = abort_q;
    sof_tag   = 1'b0;
    eof_tag   = 1'b0;
    unique case (state_q)
      IDLE: begin
        gap_d = '0;
        if (bus.valid_in) begin
          sof_tag   = 1'b1;
          sym_idx_d = 7'd1;
          state_d   = FRAME;
        end
      end
      FRAME: begin
        if (bus.valid_in) begin
          gap_d = '0;
          if (sym_idx_q == LAST_IDX) begin
            eof_tag   = 1'b1;
            done_d    = 1'b1;
            count_d   = count_q + 16'd1;
            sym_idx_d = '0;
            state_d   = IDLE;
          end else begin
            sym_idx_d = sym_idx_q + 7'd1;
          end
        end else if (gap_q == GAP_LAST) begin
          abort_d   = 1'b1;
          sym_idx_d = '0;
          gap_d     = '0;
          state_d   = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Dropped symbols still walk the frame FSM above so alignment survives overflow.
  always_comb begin
    ovf_d    = ovf_q | (bus.valid_in & ~bus.ready_out);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = {sof_tag, eof_tag, bus.I_comp[15], bus.Q_comp[15]};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_50 or negedge reset_N) begin
    if (!reset_N) begin
      state_q   <= IDLE;
      sym_idx_q <= '0;
      gap_q     <= '0;
      done_q    <= 1'b0;
      count_q   <= '0;
      abort_q   <= 1'b0;
      ovf_q     <= 1'b0;
      level_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      sym_idx_q <= sym_idx_d;
      gap_q     <= gap_d;
      done_q    <= done_d;
      count_q   <= count_d;
      abort_q   <= abort_d;
      ovf_q     <= ovf_d;
      level_q   <= level_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mem_q     <= mem_d;
    end
  end

  assign sym_index   = sym_idx_q;
  assign frame_done  = done_q;
  assign frame_count = count_q;
  assign frame_abort = abort_q;
  assign overflow    = ovf_q;
  assign fifo_level  = level_q;

`ifdef QPSK_DEMAP_AMP_CHECK_EN
  logic [7:0]  amp_q, amp_d;
  logic [15:0] mag_i, mag_q;
  logic [15:0] dev_i, dev_q;
  logic        amp_bad;

  // -32768 has no positive twin in Q15, so it saturates to 32767.
  function automatic logic [15:0] mag(input logic signed [15:0] x);
    if (x == 16'sh8000) return 16'h7FFF;
    else if (x[15])     return 16'(-x);
    else                return 16'(x);
  endfunction

  always_comb begin
    mag_i   = mag(bus.I_comp);
    mag_q   = mag(bus.Q_comp);
    dev_i   = (mag_i >= 16'(NOM_AMP)) ? mag_i - 16'(NOM_AMP) : 16'(NOM_AMP) - mag_i;
    dev_q   = (mag_q >= 16'(NOM_AMP)) ? mag_q - 16'(NOM_AMP) : 16'(NOM_AMP) - mag_q;
    amp_bad = (dev_i > AMP_TOL) || (dev_q > AMP_TOL);
    amp_d   = amp_q;
    if (push && amp_bad && (amp_q != 8'hFF)) amp_d = amp_q + 8'd1;
  end

  always_ff @(posedge clk_50 or negedge reset_N) begin
    if (!reset_N) amp_q <= '0;
    else          amp_q <= amp_d;
  end

  assign amp_err_count = amp_q;
`else
  logic unused_mag_bits;
  assign unused_mag_bits = ^{bus.I_comp[14:0], bus.Q_comp[14:0]};
  assign amp_err_count   = '0;
`endif
endmodule

// File: tb/tb_qpsk_demapper_deframer.sv
// Scoreboard bench for qpsk_demapper_deframer: expected FIFO entries queued at
// drive time, compared as the FIFO head is popped.
module tb_qpsk_demapper_deframer;
  logic        clk_50 = 1'b0;
  logic        reset_N = 1'b0;
  logic [6:0]  sym_index;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        frame_abort;
  logic        overflow;
  logic [4:0]  fifo_level;
  logic [7:0]  amp_err_count;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [3:0] sb[$];

`ifdef QPSK_DEMAP_AMP_CHECK_EN
  localparam int EXP_AMP = 2;
`else
  localparam int EXP_AMP = 0;
`endif

  qpsk_demapper_deframer_if bus();

  qpsk_demapper_deframer dut (
    .clk_50        (clk_50),
    .reset_N       (reset_N),
    .bus           (bus),
    .sym_index     (sym_index),
    .frame_done    (frame_done),
    .frame_count   (frame_count),
    .frame_abort   (frame_abort),
    .overflow      (overflow),
    .fifo_level    (fifo_level),
    .amp_err_count (amp_err_count)
  );

  always #10 clk_50 = ~clk_50;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", pass_cnt, chk_cnt);
    $fatal(1, "watchdog");
  end

  // Scoreboard compare: head is sampled on the falling edge before the popping rising edge.
  always @(negedge clk_50) begin
    if (reset_N && bus.dibit_valid && bus.dibit_ready) begin
      chk_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: got entry %b, required no entry", {bus.dibit_sof, bus.dibit_eof, bus.dibit_out});
      end else begin
        logic [3:0] exp_e;
        exp_e = sb.pop_front();
        if ({bus.dibit_sof, bus.dibit_eof, bus.dibit_out} !== exp_e)
          $display("FAIL sb_entry: got %b, required %b", {bus.dibit_sof, bus.dibit_eof, bus.dibit_out}, exp_e);
        else
          pass_cnt++;
      end
    end
  end

  task automatic drive(input logic [15:0] i, input logic [15:0] q, input logic exp_push,
                       input logic sof, input logic eof);
    bus.valid_in = 1'b1;
    bus.I_comp   = i;
    bus.Q_comp   = q;
    if (exp_push) sb.push_back({sof, eof, i[15], q[15]});
    @(posedge clk_50);
    #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.valid_in = 1'b0;
    repeat (n) begin
      @(posedge clk_50);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_N = 1'b0;
    bus.valid_in = 1'b0;
    bus.dibit_ready = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk_50);
    @(negedge clk_50);
    reset_N = 1'b1;
    @(posedge clk_50);
    #1;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    bus.dibit_ready = 1'b1;
    while (sb.size() != 0 && k < 60) begin
      idle(1);
      k++;
    end
    idle(2);
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL %s_drain: got %0d entries left, required 0", name, sb.size());
    else pass_cnt++;
    chk_cnt++;
    if (fifo_level !== 5'd0) $display("FAIL %s_level0: got %0d, required 0", name, fifo_level);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    bus.valid_in = 1'b0;
    bus.I_comp = '0;
    bus.Q_comp = '0;
    bus.dibit_ready = 1'b0;
    reset_N = 1'b0;
    repeat (2) @(posedge clk_50);
    #1;
    chk_cnt++;
    if ({bus.ready_out, bus.dibit_valid, bus.dibit_out, sym_index, frame_done, frame_count,
         frame_abort, overflow, fifo_level, amp_err_count} !== '0)
      $display("FAIL reset_held: outputs not all zero, ready_out=%b level=%0d", bus.ready_out, fifo_level);
    else pass_cnt++;
    @(negedge clk_50);
    reset_N = 1'b1;
    @(posedge clk_50);
    #1;
    chk_cnt++;
    if (bus.ready_out !== 1'b1) $display("FAIL reset_ready: got %b, required 1", bus.ready_out);
    else pass_cnt++;
    chk_cnt++;
    if ({bus.dibit_valid, sym_index, frame_count, overflow, frame_abort, fifo_level} !== '0)
      $display("FAIL reset_release: got sym_index=%0d level=%0d, required 0", sym_index, fifo_level);
    else pass_cnt++;
  endtask

  task automatic test_full_frame();
    int done_seen;
    logic [15:0] v;
    done_seen = 0;
    bus.dibit_ready = 1'b1;
    for (int i = 0; i < 96; i++) begin
      v = (i % 2 == 0) ? 16'h5A82 : 16'hA57E;
      drive(v, v, 1'b1, i == 0, i == 95);
      if (frame_done) done_seen++;
    end
    idle(1);
    if (frame_done) done_seen++;
    chk_cnt++;
    if (done_seen != 1) $display("FAIL frame_done_pulses: got %0d, required 1", done_seen);
    else pass_cnt++;
    chk_cnt++;
    if (frame_count !== 16'd1) $display("FAIL frame_count: got %0d, required 1", frame_count);
    else pass_cnt++;
    chk_cnt++;
    if (overflow !== 1'b0) $display("FAIL frame_overflow: got %b, required 0", overflow);
    else pass_cnt++;
    chk_cnt++;
    if (sym_index !== 7'd0) $display("FAIL frame_sym_index: got %0d, required 0", sym_index);
    else pass_cnt++;
    drain("full_frame");
  endtask

  task automatic test_overflow();
    do_reset();
    bus.dibit_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(16'h5A82, 16'hA57E, i < 16, i == 0, 1'b0);
      if (i == 15) begin
        chk_cnt++;
        if (fifo_level !== 5'd16) $display("FAIL ovf_level_full: got %0d, required 16", fifo_level);
        else pass_cnt++;
        chk_cnt++;
        if (bus.ready_out !== 1'b0) $display("FAIL ovf_ready_low: got %b, required 0", bus.ready_out);
        else pass_cnt++;
        chk_cnt++;
        if (overflow !== 1'b0) $display("FAIL ovf_not_yet: got %b, required 0", overflow);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b, required 1", overflow);
    else pass_cnt++;
    chk_cnt++;
    if (sym_index !== 7'd20) $display("FAIL ovf_sym_index: got %0d, required 20", sym_index);
    else pass_cnt++;
    drain("overflow");
  endtask

  task automatic test_gap_abort();
    logic [15:0] a, b;
    do_reset();
    bus.dibit_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      drive(a, b, 1'b1, i == 0, 1'b0);
    end
    idle(3);
    chk_cnt++;
    if (frame_abort !== 1'b0) $display("FAIL gap_tolerated: got abort=%b, required 0", frame_abort);
    else pass_cnt++;
    chk_cnt++;
    if (sym_index !== 7'd40) $display("FAIL gap_hold_index: got %0d, required 40", sym_index);
    else pass_cnt++;
    idle(1);
    chk_cnt++;
    if (frame_abort !== 1'b1) $display("FAIL gap_abort: got %b, required 1", frame_abort);
    else pass_cnt++;
    chk_cnt++;
    if (sym_index !== 7'd0) $display("FAIL gap_index_zero: got %0d, required 0", sym_index);
    else pass_cnt++;
    drive(16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0);
    chk_cnt++;
    if (sym_index !== 7'd1) $display("FAIL gap_restart_index: got %0d, required 1", sym_index);
    else pass_cnt++;
    drain("gap_abort");
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.dibit_ready = 1'b0;
    for (int i = 0; i < 8; i++) drive(16'($urandom), 16'($urandom), 1'b1, i == 0, 1'b0);
    chk_cnt++;
    if (fifo_level !== 5'd8) $display("FAIL b2b_fill: got %0d, required 8", fifo_level);
    else pass_cnt++;
    bus.dibit_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(16'($urandom), 16'($urandom), 1'b1, 1'b0, 1'b0);
      chk_cnt++;
      if (fifo_level !== 5'd8) $display("FAIL b2b_level: cycle %0d got %0d, required 8", i, fifo_level);
      else pass_cnt++;
    end
    drain("back_to_back");
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    bus.dibit_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (i == 45) bus.dibit_ready = 1'b0;
      drive(16'($urandom), 16'($urandom), 1'b1, i == 0, 1'b0);
    end
    chk_cnt++;
    if (fifo_level !== 5'd6) $display("FAIL mid_queued: got %0d, required 6", fifo_level);
    else pass_cnt++;
    #4;
    reset_N = 1'b0;
    #1;
    chk_cnt++;
    if ({bus.ready_out, bus.dibit_valid, bus.dibit_out, bus.dibit_sof, bus.dibit_eof, sym_index,
         frame_done, frame_count, frame_abort, overflow, fifo_level, amp_err_count} !== '0)
      $display("FAIL mid_async_reset: got level=%0d sym_index=%0d valid=%b, required all 0",
               fifo_level, sym_index, bus.dibit_valid);
    else pass_cnt++;
    sb.delete();
    @(negedge clk_50);
    reset_N = 1'b1;
    @(posedge clk_50);
    #1;
    bus.dibit_ready = 1'b1;
    for (int i = 0; i < 96; i++) drive(16'($urandom), 16'($urandom), 1'b1, i == 0, i == 95);
    chk_cnt++;
    if (frame_count !== 16'd1) $display("FAIL mid_refr_count: got %0d, required 1", frame_count);
    else pass_cnt++;
    chk_cnt++;
    if (frame_abort !== 1'b0) $display("FAIL mid_refr_abort: got %b, required 0", frame_abort);
    else pass_cnt++;
    drain("reset_mid_frame");
  endtask

  task automatic test_amp_check();
    do_reset();
    bus.dibit_ready = 1'b1;
    drive(16'h5A82, 16'h5A82, 1'b1, 1'b1, 1'b0);
    drive(16'h4000, 16'h5A82, 1'b1, 1'b0, 1'b0);
    drive(16'h8000, 16'h5A82, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk_cnt++;
    if (amp_err_count !== 8'(EXP_AMP)) $display("FAIL amp_count: got %0d, required %0d", amp_err_count, EXP_AMP);
    else pass_cnt++;
    drain("amp_check");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_overflow();
    test_gap_abort();
    test_back_to_back();
    test_reset_mid_frame();
    test_amp_check();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
